fetch_pc_redirect: RTL and testbench
====================================

Name: fetch_pc_redirect

Overview:
Fetch-side consumer of the execute-stage next-PC/jump decision. Owns the architectural fetch PC and drives the instruction-memory request handshake. Fills the IF/ID pipeline register and applies execute-stage redirects (JAL/JALR): it flushes younger stages and drops in-flight fetches. It also raises an instruction-address-misaligned exception toward the CSR unit.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
TRAP_VEC, 32'h0000_0100, fetch address after a misaligned redirect

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
stall_i  in  1  hazard unit: hold IF/ID, no new accepted fetch
redirect_valid  in  1  execute stage presents a control-flow decision
redirect_type  in  2  00 none, 01 JAL, 10 JALR, 11 reserved
redirect_pc  in  32  target from execute (JALR LSB already cleared)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  fetch address
imem_resp_valid  in  1  instruction word returned
imem_resp_data  in  32  instruction word
ifid_valid  out  1  IF/ID holds a live instruction
ifid_pc  out  32  PC of ifid_instr
ifid_pc_plus4  out  32  ifid_pc + 4
ifid_instr  out  32  instruction word
flush_ifid  out  1  kill IF/ID contents
flush_idex  out  1  kill ID/EX contents
exc_misalign  out  1  one-cycle instruction-address-misaligned pulse
exc_tval  out  32  offending target address

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=FETCH, no outstanding request, skid buffer empty. All outputs 0 except imem_addr=RESET_PC.
- Active redirect: redirect_valid=1 and redirect_type in {01,10}. Type 00 and type 11 are ignored: no flush, no PC change.
- States:
  - FETCH: imem_req_valid=1, imem_addr=pc.
    - On valid&ready: pc<=pc+4 (32-bit wrap, FFFF_FFFC -> 0). Go to WAIT.
    - While ready=0: imem_addr and imem_req_valid hold stable.
  - WAIT: one request outstanding, imem_req_valid=0.
    - On imem_resp_valid, go to FETCH.
    - Not-killed response, stall_i=0: load ifid_* (valid=1), same edge.
    - Not-killed response, stall_i=1: capture into 1-entry skid buffer. Stay in FETCH but suppress requests (imem_req_valid=0) while the skid is full.
  - DRAIN: outstanding request was killed by a redirect. The response is discarded. On response go to FETCH.
- Max one outstanding request; response latency >=1 cycle after acceptance.
- stall_i=1 without an active redirect:
  - ifid_* hold.
  - A request already valid&!ready may still be accepted.
  - Skid contents move to IF/ID on the first cycle stall_i=0. Skid then empties and requests resume next cycle.
- Active redirect, same cycle:
  - flush_ifid=1 and flush_idex=1, combinational on redirect_valid.
  - At the edge:
    - pc<=redirect_pc.
    - ifid_valid<=0.
    - Skid cleared.
    - WAIT goes to DRAIN.
    - An in-progress FETCH handshake accepted this cycle is also treated as killed (goes to DRAIN).
  - Redirect overrides stall_i.
  - A response arriving in the redirect cycle is discarded.
- Misaligned: active redirect with redirect_pc[1:0]!=00.
  - Flush as above.
  - pc<=TRAP_VEC.
  - exc_misalign=1 for exactly one cycle (registered, the cycle after the redirect).
  - exc_tval=redirect_pc, held until the next exception.
- First new request after a redirect appears the cycle after the redirect edge (FETCH), or after the drained response (DRAIN).
- ifid_pc_plus4 computed from ifid_pc, 32-bit wrap.
- Reset asserted mid-transaction: any later imem_resp_valid is ignored until a new request is accepted.

Test Plan:
- Reset, imem ready always, 1-cycle response → addresses 0,4,8,C on successive requests; ifid_pc tracks 0,4,8 with ifid_instr matching the memory words.
- imem_req_ready=0 for 3 cycles at addr 8 → imem_addr stays 8, imem_req_valid stays 1, pc unchanged; accepted on the 4th cycle.
- stall_i=1 for 4 cycles while a response arrives → ifid holds old value, response goes to skid, no new request. On release the skid word appears in IF/ID and requests resume.
- Request to 0x10 outstanding, redirect JAL to 0x200 → flush_ifid=flush_idex=1 that cycle. The 0x10 response is dropped; next imem_addr=0x200; next ifid_pc=0x200.
- JALR redirect_pc=0x0000_0102 → flush asserted, exc_misalign pulse of 1 cycle, exc_tval=0x102; next fetch at TRAP_VEC=0x100.
- redirect_type=11 with redirect_pc=0x400, then rst pulse during WAIT → no flush and no PC change for type 11. After reset imem_addr=RESET_PC, ifid_valid=0, and the stale response is ignored.

Source files
------------

// File: rtl/fetch_pc_redirect.sv
// Fetch PC owner: drives the imem request handshake, fills IF/ID, applies
// execute-stage JAL/JALR redirects and raises instruction-address-misaligned.
module fetch_pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_type,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic        exc_misalign,
    output logic [31:0] exc_tval
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        exc_q, exc_d;
    logic [31:0] tval_q, tval_d;

    logic redir_act;
    logic redir_mis;
    logic req_fire;
    logic resp_live;
    logic busy_next;

    always_comb begin
        redir_act = redirect_valid && (redirect_type == 2'b01 || redirect_type == 2'b10);
        redir_mis = redir_act && (redirect_pc[1:0] != 2'b00);
        // A full skid means IF/ID is backed up; no point fetching further.
        imem_req_valid = !rst && (state_q == S_FETCH) && !skid_valid_q;
        req_fire  = imem_req_valid && imem_req_ready;
        resp_live = (state_q == S_WAIT) && imem_resp_valid && !redir_act;
        busy_next = req_fire
                  || (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_resp_valid);
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        exc_d        = redir_mis;
        tval_d       = redir_mis ? redirect_pc : tval_q;

        case (state_q)
            S_FETCH: begin
                if (req_fire) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                end
            end
            S_WAIT, S_DRAIN: begin
                if (imem_resp_valid) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (!stall_i) begin
            if (skid_valid_q) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = skid_pc_q;
                ifid_instr_d = skid_instr_q;
                skid_valid_d = 1'b0;
            end else if (resp_live) begin
                ifid_valid_d = 1'b1;
                ifid_pc_d    = req_pc_q;
                ifid_instr_d = imem_resp_data;
            end else begin
                ifid_valid_d = 1'b0;
            end
        end else if (resp_live) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_instr_d = imem_resp_data;
        end

        // Redirect wins over stall and over any same-cycle response; a request
        // still in flight after this edge must be drained and discarded.
        if (redir_act) begin
            pc_d         = redir_mis ? TRAP_VEC : redirect_pc;
            ifid_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            state_d      = busy_next ? S_DRAIN : S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= 32'd0;
            skid_instr_q <= 32'd0;
            exc_q        <= 1'b0;
            tval_q       <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            exc_q        <= exc_d;
            tval_q       <= tval_d;
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_valid    = ifid_valid_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = rst ? 32'd0 : (ifid_pc_q + 32'd4);
    assign ifid_instr    = ifid_instr_q;
    assign flush_ifid    = redir_act;
    assign flush_idex    = redir_act;
    assign exc_misalign  = exc_q;
    assign exc_tval      = tval_q;

endmodule

// File: tb/tb_fetch_pc_redirect.sv
// Randomized bench for fetch_pc_redirect: transaction-level reference model,
// per-cycle output compare, and directed scenarios pinned with literals.
module tb_fetch_pc_redirect;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_type = 2'b00;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        ifid_valid;
    logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;
    logic        flush_ifid, flush_idex, exc_misalign;
    logic [31:0] exc_tval;

    always #5 clk = ~clk;

    fetch_pc_redirect #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .redirect_valid(redirect_valid), .redirect_type(redirect_type), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_instr(ifid_instr), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .exc_misalign(exc_misalign), .exc_tval(exc_tval)
    );

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // stimulus for the next cycle
    logic        s_rst = 1'b0, s_stall = 1'b0, s_rv = 1'b0, s_ready = 1'b1;
    logic [1:0]  s_rtype = 2'b00;
    logic [31:0] s_rpc = 32'd0;
    int          lat = 1;

    // memory responder (one pending response)
    bit          rp_pend = 0;
    int          rp_due = 0;
    logic [31:0] rp_addr = 32'd0;
    int          cyc = 0;

    // reference model
    bit          m_busy, m_kill, m_ifv, m_exc;
    logic [31:0] m_pc, m_raddr, m_ifpc, m_ifin, m_tval;
    logic [31:0] sk_pc[$];
    logic [31:0] sk_in[$];

    // observations of the last cycle
    logic        o_reqv, o_ifv, o_flush, o_exc, o_acc;
    logic [31:0] o_addr, o_ifpc, o_ifin, o_tval, o_p4, last_acc;
    logic [31:0] acc_q[$];
    logic [31:0] if_q[$];
    logic [31:0] ifin_q[$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", n, cyc, a, e);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_kill = 0; m_ifv = 0; m_exc = 0;
        m_pc = RESET_PC; m_raddr = RESET_PC; m_ifpc = 0; m_ifin = 0; m_tval = 0;
        sk_pc.delete(); sk_in.delete();
    endtask

    task automatic model_update(input bit hs);
        bit act, mis, live, nbusy;
        act   = s_rv && (s_rtype == 2'b01 || s_rtype == 2'b10);
        mis   = act && (s_rpc[1:0] != 2'b00);
        live  = m_busy && !m_kill && imem_resp_valid && !act;
        nbusy = (m_busy && !imem_resp_valid) || hs;
        m_exc = mis;
        if (mis) m_tval = s_rpc;
        if (act) begin
            m_busy = nbusy;
            m_kill = nbusy;
            m_pc   = mis ? TRAP_VEC : s_rpc;
            m_ifv  = 0;
            sk_pc.delete(); sk_in.delete();
        end else begin
            if (!s_stall) begin
                if (sk_pc.size() != 0) begin
                    m_ifv = 1; m_ifpc = sk_pc.pop_front(); m_ifin = sk_in.pop_front();
                end else if (live) begin
                    m_ifv = 1; m_ifpc = m_raddr; m_ifin = imem_resp_data;
                end else begin
                    m_ifv = 0;
                end
            end else if (live) begin
                sk_pc.push_back(m_raddr); sk_in.push_back(imem_resp_data);
            end
            if (hs) begin
                m_raddr = m_pc;
                m_pc    = m_pc + 32'd4;
            end
            m_kill = hs ? 1'b0 : (nbusy ? m_kill : 1'b0);
            m_busy = nbusy;
        end
    endtask

    // one clock cycle: drive at negedge, compare, advance model at posedge
    task automatic step();
        bit e_req, e_fl;
        rst            = s_rst;
        stall_i        = s_stall;
        redirect_valid = s_rv;
        redirect_type  = s_rtype;
        redirect_pc    = s_rpc;
        imem_req_ready = s_ready && !rp_pend;
        if (rp_pend && cyc >= rp_due) begin
            imem_resp_valid = 1'b1; imem_resp_data = memw(rp_addr); rp_pend = 0;
        end else begin
            imem_resp_valid = 1'b0; imem_resp_data = $urandom;
        end
        #1;
        if (rst) model_reset();
        e_req = !rst && !m_busy && (sk_pc.size() == 0);
        e_fl  = s_rv && (s_rtype == 2'b01 || s_rtype == 2'b10);
        chk("imem_req_valid", imem_req_valid, e_req);
        chk("imem_addr", imem_addr, m_pc);
        chk("flush_ifid", flush_ifid, e_fl);
        chk("flush_idex", flush_idex, e_fl);
        chk("ifid_valid", ifid_valid, m_ifv);
        chk("exc_misalign", exc_misalign, m_exc);
        chk("exc_tval", exc_tval, m_tval);
        if (m_ifv) begin
            chk("ifid_pc", ifid_pc, m_ifpc);
            chk("ifid_pc_plus4", ifid_pc_plus4, m_ifpc + 32'd4);
            chk("ifid_instr", ifid_instr, m_ifin);
        end
        o_reqv = imem_req_valid; o_addr = imem_addr; o_ifv = ifid_valid; o_ifpc = ifid_pc;
        o_ifin = ifid_instr; o_flush = flush_ifid; o_exc = exc_misalign; o_tval = exc_tval;
        o_p4 = ifid_pc_plus4;
        o_acc = imem_req_valid && imem_req_ready;
        if (o_acc) begin last_acc = imem_addr; acc_q.push_back(imem_addr); end
        if (ifid_valid) begin if_q.push_back(ifid_pc); ifin_q.push_back(ifid_instr); end
        @(posedge clk);
        if (!rst) model_update(e_req && imem_req_ready);
        if (o_acc && !rst) begin rp_pend = 1; rp_addr = last_acc; rp_due = cyc + lat; end
        cyc++;
        @(negedge clk);
    endtask

    task automatic quiet();
        s_rst = 0; s_stall = 0; s_rv = 0; s_rtype = 0; s_rpc = 0; s_ready = 1;
    endtask

    task automatic do_reset();
        quiet(); s_rst = 1; step(); s_rst = 0;
    endtask

    task automatic next_acc(output logic [31:0] a);
        bit got = 0;
        a = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (o_acc) begin got = 1; a = last_acc; end
        end
        if (!got) chk("acc_timeout", 0, 1);
    endtask

    task automatic next_ifv(output logic [31:0] p);
        bit got = 0;
        p = 32'hDEAD_BEEF;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (o_ifv) begin got = 1; p = o_ifpc; end
        end
        if (!got) chk("ifv_timeout", 0, 1);
    endtask

    initial begin
        logic [31:0] a, p;
        model_reset();
        @(negedge clk);

        // reset values
        do_reset();
        chk("rst_reqv", o_reqv, 0); chk("rst_addr", o_addr, RESET_PC);
        chk("rst_ifv", o_ifv, 0); chk("rst_exc", o_exc, 0); chk("rst_p4", o_p4, 0);

        // streaming fetch, 1-cycle memory
        lat = 1; acc_q.delete(); if_q.delete(); ifin_q.delete();
        for (int i = 0; i < 8; i++) step();
        chk("seq_a0", acc_q[0], 32'h0); chk("seq_a1", acc_q[1], 32'h4);
        chk("seq_a2", acc_q[2], 32'h8); chk("seq_a3", acc_q[3], 32'hC);
        chk("seq_if0", if_q[0], 32'h0); chk("seq_if1", if_q[1], 32'h4);
        chk("seq_if2", if_q[2], 32'h8); chk("seq_in1", ifin_q[1], memw(32'h4));

        // backpressure at address 8
        do_reset();
        for (int i = 0; i < 20 && !(imem_req_valid && imem_addr == 32'h8); i++) step();
        s_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_reqv", o_reqv, 1); chk("bp_addr", o_addr, 32'h8); chk("bp_acc", o_acc, 0);
        end
        s_ready = 1; step();
        chk("bp_accept", o_acc, 1); chk("bp_accept_addr", last_acc, 32'h8);

        // stall while response for 8 arrives -> skid, then release
        s_stall = 1;
        step();
        for (int i = 0; i < 3; i++) begin step(); chk("stall_noreq", o_reqv, 0); end
        s_stall = 0; step(); chk("release_noreq", o_reqv, 0);
        step();
        chk("skid_ifv", o_ifv, 1); chk("skid_ifpc", o_ifpc, 32'h8);
        chk("skid_instr", o_ifin, memw(32'h8)); chk("resume_req", o_reqv, 1);

        // redirect while request to 0x10 is outstanding
        do_reset(); lat = 3;
        for (int i = 0; i < 8 && last_acc != 32'h10; i++) next_acc(a);
        s_rv = 1; s_rtype = 2'b01; s_rpc = 32'h200; step();
        chk("jal_flush", o_flush, 1);
        quiet(); next_acc(a); chk("jal_first_req", a, 32'h200);
        next_ifv(p); chk("jal_first_ifpc", p, 32'h200);

        // misaligned JALR
        s_rv = 1; s_rtype = 2'b10; s_rpc = 32'h102; step();
        chk("mis_flush", o_flush, 1);
        quiet(); step();
        chk("mis_exc1", o_exc, 1); chk("mis_tval", o_tval, 32'h102);
        step();
        chk("mis_exc2", o_exc, 0); chk("mis_tval_hold", o_tval, 32'h102);
        next_acc(a); chk("mis_trap_req", a, TRAP_VEC);

        // PC wrap
        s_rv = 1; s_rtype = 2'b01; s_rpc = 32'hFFFF_FFF8; step(); quiet();
        next_acc(a); chk("wrap0", a, 32'hFFFF_FFF8);
        next_acc(a); chk("wrap1", a, 32'hFFFF_FFFC);
        next_acc(a); chk("wrap2", a, 32'h0);

        // reserved type ignored, then reset mid-transaction
        s_rv = 1; s_rtype = 2'b11; s_rpc = 32'h400; step();
        chk("rsv_noflush", o_flush, 0);
        quiet(); next_acc(a); chk("rsv_no_pc_change", (a == 32'h400), 0);
        s_rst = 1; step();
        chk("mrst_reqv", o_reqv, 0); chk("mrst_addr", o_addr, RESET_PC);
        chk("mrst_ifv", o_ifv, 0); chk("mrst_tval", o_tval, 0);
        s_rst = 0;
        for (int i = 0; i < 5; i++) begin step(); chk("stale_ignored", o_ifv, 0); end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s_rst   = ($urandom_range(0, 199) == 0);
            s_stall = ($urandom_range(0, 3) == 0);
            s_rv    = !s_rst && ($urandom_range(0, 9) == 0);
            s_rtype = 2'($urandom_range(0, 3));
            s_rpc   = {22'd0, 10'($urandom_range(0, 1023))};
            if ($urandom_range(0, 3) != 0) s_rpc[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) s_rpc = 32'hFFFF_FFF0;
            s_ready = ($urandom_range(0, 9) < 7);
            lat     = $urandom_range(1, 3);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
